// File: rtl/peripheral_showresult.sv
// Snapshot viewer: captures dataA/dataB/dataR when the loader reports ready and
// shows one halfword at a time as four hex digits, stepped by a debounced enter.
module peripheral_showresult #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enter,
    input  logic        inputdata_ready,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    input  logic [31:0] dataR,
    output logic [2:0]  view,
    output logic        snapshot_valid,
    output logic [6:0]  disp3,
    output logic [6:0]  disp2,
    output logic [6:0]  disp1,
    output logic [6:0]  disp0
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [6:0] DASH = 7'b0111111;

    typedef enum logic [2:0] {
        V_A_LO   = 3'd0,
        V_A_HI   = 3'd1,
        V_B_LO   = 3'd2,
        V_B_HI   = 3'd3,
        V_R_LO   = 3'd4,
        V_R_HI   = 3'd5,
        V_UNUSED = 3'd6,
        V_WAIT   = 3'd7
    } view_t;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   s, enter_pulse;

    view_t       view_q;
    logic        valid_q;
    logic [31:0] snap_a_q, snap_b_q, snap_r_q;
    logic [27:0] disp_q, disp_d;
    logic [15:0] half;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], enter};
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = '0;
        if (s) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
    end

    // Counter saturates, so a held button matches CNT_LAST exactly once.
    assign enter_pulse = s && (cnt_q == CNT_LAST);

    always_comb begin
        half = '0;
        case (view_q)
            V_A_LO: half = snap_a_q[15:0];
            V_A_HI: half = snap_a_q[31:16];
            V_B_LO: half = snap_b_q[15:0];
            V_B_HI: half = snap_b_q[31:16];
            V_R_LO: half = snap_r_q[15:0];
            V_R_HI: half = snap_r_q[31:16];
            default: half = '0;
        endcase
    end

    always_comb begin
        disp_d = {4{DASH}};
        if (view_q <= V_R_HI) begin
            disp_d = {hex7(half[15:12]), hex7(half[11:8]), hex7(half[7:4]), hex7(half[3:0])};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            view_q   <= V_WAIT;
            valid_q  <= 1'b0;
            snap_a_q <= '0;
            snap_b_q <= '0;
            snap_r_q <= '0;
            disp_q   <= {4{DASH}};
        end else begin
            disp_q <= disp_d;
            if (inputdata_ready) begin
                snap_a_q <= dataA;
                snap_b_q <= dataB;
                snap_r_q <= dataR;
                valid_q  <= 1'b1;
                view_q   <= V_A_LO;
            end else if (enter_pulse) begin
                case (view_q)
                    V_WAIT:   view_q <= V_WAIT;
                    V_R_HI:   view_q <= V_A_LO;
                    V_UNUSED: view_q <= V_A_LO;
                    default:  view_q <= view_t'(view_q + 3'd1);
                endcase
            end
        end
    end

    assign view           = view_q;
    assign snapshot_valid = valid_q;
    assign disp3          = disp_q[27:21];
    assign disp2          = disp_q[20:14];
    assign disp1          = disp_q[13:7];
    assign disp0          = disp_q[6:0];

endmodule

// File: tb/tb_peripheral_showresult.sv
// Bench for peripheral_showresult: view-step table plus hand-written sequences
// for reset, glitch rejection and ready/enter coincidence.
module tb_peripheral_showresult;

    logic        clk = 1'b0;
    logic        reset, enter, inputdata_ready;
    logic [31:0] dataA, dataB, dataR;
    logic [2:0]  view;
    logic        snapshot_valid;
    logic [6:0]  disp3, disp2, disp1, disp0;

    localparam logic [27:0] DASHES = {4{7'b0111111}};

    peripheral_showresult #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .enter(enter), .inputdata_ready(inputdata_ready),
        .dataA(dataA), .dataB(dataB), .dataR(dataR),
        .view(view), .snapshot_valid(snapshot_valid),
        .disp3(disp3), .disp2(disp2), .disp1(disp1), .disp0(disp0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  view;
        logic [27:0] disp;
    } exp_t;

    typedef struct {
        logic [2:0]  view;
        logic [15:0] half;
        logic        clobber;
    } vec_t;

    exp_t sb[$];
    int   nvec = 0;
    int   nbad = 0;

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: seg = 7'b1000000;  4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;  4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;  4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;  4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;  4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;  4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;  4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;  default: seg = 7'b0001110;
        endcase
    endfunction

    function automatic logic [27:0] shown(input logic [15:0] h);
        shown = {seg(h[15:12]), seg(h[11:8]), seg(h[7:4]), seg(h[3:0])};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [2:0] v, input logic [15:0] h);
        exp_t e;
        e.view = v;
        e.disp = shown(h);
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({name, "_view"}, {29'd0, view}, {29'd0, e.view});
            check({name, "_disp"}, {4'd0, disp3, disp2, disp1, disp0}, {4'd0, e.disp});
        end
    endtask

    // Holds enter for 'hold' cycles, then releases it long enough for the
    // debouncer to clear; reports the number of view changes and the first one.
    task automatic press(input int hold, output int adv, output int first);
        logic [2:0] prev;
        adv   = 0;
        first = -1;
        enter = 1'b1;
        for (int i = 1; i <= hold + 3; i++) begin
            if (i == hold + 1) enter = 1'b0;
            prev = view;
            tick();
            if (view !== prev) begin
                adv++;
                if (first < 0) first = i;
            end
        end
    endtask

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int adv, first;

        vecs[0] = '{3'd2, 16'hDEF0, 1'b1};
        vecs[1] = '{3'd3, 16'h9ABC, 1'b0};
        vecs[2] = '{3'd4, 16'hBEEF, 1'b0};
        vecs[3] = '{3'd5, 16'hACE0, 1'b0};
        vecs[4] = '{3'd0, 16'h5678, 1'b0};
        vecs[5] = '{3'd1, 16'h1234, 1'b0};
        vecs[6] = '{3'd2, 16'hDEF0, 1'b0};
        vecs[7] = '{3'd3, 16'h9ABC, 1'b0};

        reset = 1'b1; enter = 1'b0; inputdata_ready = 1'b0;
        dataA = '0; dataB = '0; dataR = '0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            enter = ~enter;
            tick();
        end
        reset = 1'b0; enter = 1'b0;
        check("rst_view", {29'd0, view}, 32'd7);
        check("rst_valid", {31'd0, snapshot_valid}, 32'd0);
        check("rst_disp", {4'd0, disp3, disp2, disp1, disp0}, {4'd0, DASHES});
        press(8, adv, first);
        check("wait_adv", adv, 0);
        check("wait_view", {29'd0, view}, 32'd7);
        check("wait_disp", {4'd0, disp3, disp2, disp1, disp0}, {4'd0, DASHES});

        dataA = 32'h12345678; dataB = 32'h9ABCDEF0; dataR = 32'hACE0BEEF;
        inputdata_ready = 1'b1;
        tick();
        inputdata_ready = 1'b0;
        check("cap_view", {29'd0, view}, 32'd0);
        check("cap_valid", {31'd0, snapshot_valid}, 32'd1);
        tick();
        check("cap_disp", {4'd0, disp3, disp2, disp1, disp0}, {4'd0, shown(16'h5678)});

        push_exp(3'd1, 16'h1234);
        press(10, adv, first);
        check("hold_adv", adv, 1);
        check("hold_lat", first, 6);
        pop_cmp("hold");

        push_exp(3'd1, 16'h1234);
        press(3, adv, first);
        check("glitch_adv", adv, 0);
        pop_cmp("glitch");

        for (int k = 0; k < 8; k++) begin
            if (vecs[k].clobber) begin
                dataA = '0; dataB = '0; dataR = '0;
            end
            push_exp(vecs[k].view, vecs[k].half);
            press(8, adv, first);
            check($sformatf("step%0d_adv", k), adv, 1);
            check($sformatf("step%0d_lat", k), first, 6);
            pop_cmp($sformatf("step%0d", k));
        end

        dataA = 32'hCAFEF00D; dataB = 32'h01234567; dataR = 32'h89ABCDEF;
        enter = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        inputdata_ready = 1'b1;
        tick();
        inputdata_ready = 1'b0;
        check("coin_view", {29'd0, view}, 32'd0);
        for (int i = 0; i < 4; i++) tick();
        enter = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        push_exp(3'd0, 16'hF00D);
        pop_cmp("coin");

        push_exp(3'd1, 16'hCAFE);
        push_exp(3'd2, 16'h4567);
        push_exp(3'd3, 16'h0123);
        push_exp(3'd4, 16'hCDEF);
        for (int k = 0; k < 4; k++) begin
            press(6, adv, first);
            pop_cmp($sformatf("new%0d", k));
        end

        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst4_view", {29'd0, view}, 32'd7);
        check("rst4_disp", {4'd0, disp3, disp2, disp1, disp0}, {4'd0, DASHES});
        check("rst4_valid", {31'd0, snapshot_valid}, 32'd0);
        for (int i = 0; i < 10; i++) tick();
        check("rst4_hold", {29'd0, view}, 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
